opcheck_monitor: RTL and testbench
==================================

# opcheck_monitor

Synthesizable self-checking monitor that watches the CPU memory bus and decides pass/fail for directed instruction tests, replacing hand-inspection of RAM after simulation. It sits beside `mem` on the CPU address/data bus. It holds a parametrised number of checkpoint channels, each expecting a masked data value written to a given address. It declares PASS when every armed channel has been hit, FAIL on the first mismatching write, and TIMEOUT when the cycle budget expires.

## Interface
- `ADDR_W`, 16, bus address width
- `DATA_W`, 8, bus data width
- `CHANNELS`, 4, number of checkpoint channels (1..16)
- `CNT_W`, 16, width of cycle counter, write counter and timeout limit

- `ph1`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; 0 forces reset state immediately
- `bus_valid`  in  1  bus cycle in progress this clock
- `bus_we`  in  1  1 = write cycle
- `bus_addr`  in  ADDR_W  bus address
- `bus_wdata`  in  DATA_W  write data
- `cfg_we`  in  1  write channel config (IDLE only)
- `cfg_sel`  in  $clog2(CHANNELS) (min 1)  channel index
- `cfg_arm`  in  1  arm (1) / disarm (0) selected channel
- `cfg_addr`  in  ADDR_W  checkpoint address
- `cfg_data`  in  DATA_W  expected value
- `cfg_mask`  in  DATA_W  compare mask; 1 = bit compared
- `timeout_limit`  in  CNT_W  cycle budget, sampled at start
- `start`  in  1  IDLE→RUN
- `clear`  in  1  terminal state→IDLE, config retained
- `state`  out  3  IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4
- `done`  out  1  state is PASS, FAIL or TIMEOUT
- `pass`  out  1  state is PASS
- `hit_mask`  out  CHANNELS  channels satisfied this run
- `fail_chan`  out  $clog2(CHANNELS)  channel that mismatched
- `fail_data`  out  DATA_W  offending write data
- `cycle_count`  out  CNT_W  clocks spent in RUN
- `write_count`  out  CNT_W  valid writes seen in RUN

## Operation
- Reset: state IDLE; all channels disarmed; addr/data/mask, hit_mask, fail_chan, fail_data, counters and latched limit = 0; done = pass = 0.
- IDLE: `cfg_we` writes arm/addr/data/mask of channel `cfg_sel` (`cfg_sel` ≥ CHANNELS ignored). `start` clears hit_mask, fail_chan, fail_data and counters, latches `timeout_limit` and enters RUN. `start` and `cfg_we` together: config write applies first, and the run sees it.
- RUN: each cycle with `bus_valid & bus_we`, every armed channel with `bus_addr == cfg_addr` compares `(bus_wdata & mask)` with `(data & mask)`.
  - Match: set its hit bit. Repeated matching writes are harmless.
  - Mismatch: go to FAIL; `fail_chan` = lowest-index mismatching channel; `fail_data` = `bus_wdata`. A mismatch on an already-hit channel still fails.
  - Writes to unarmed or unmatched addresses are ignored apart from `write_count`.
- Completion: when (hit_mask | new hits) covers all armed channels → PASS. With zero armed channels, PASS the cycle after `start`.
- Timeout: `cycle_count` increments every RUN cycle and saturates at all-ones. When it equals the latched limit and no decision is made that cycle → TIMEOUT. Limit 0 means no timeout.
- Priority in one cycle: FAIL > PASS > TIMEOUT.
- Terminal states hold all outputs and counters frozen and ignore bus and cfg. `clear` → IDLE. `start` in a terminal state is ignored.
- `write_count` saturates at all-ones.
- `cfg_we` outside IDLE is ignored. `clear` in IDLE or RUN is ignored.

## Timing
- All outputs are registered and change only on `ph1` rising edge or on `reset` assertion.
- Decision latency: the deciding write sampled at edge N; `state`/`done` reflect it after edge N; visible for the whole next cycle.
- `start` at edge N → RUN after N. The first bus cycle evaluated is the one sampled at edge N+1; `cycle_count` = 1 after edge N+1.
- TIMEOUT entered at the edge where `cycle_count` would reach the limit, i.e. after exactly `timeout_limit` RUN cycles.
- `reset` low mid-run abandons the run immediately. `reset` release is not required to be synchronous to `ph1`; the first state change is on the first edge after release.

## Test plan
- Arm ch0 {addr 0x0003, data 0x22, mask 0xFF}, start, write 0x22 @0x0003 → PASS next cycle; hit_mask=0001; write_count=1.
- Arm ch0 and ch2 at 0x0010 and 0x0020 with data 0x5A, mask 0xF0; write 0x5F @0x0010, then 0x6A @0x0020 → FAIL; fail_chan=2, fail_data=0x6A, hit_mask=0001.
- Arm ch1 only, limit 5, no matching writes → TIMEOUT after exactly 5 RUN cycles; cycle_count=5; done=1, pass=0.
- Two channels on the same address, one matching and one mismatching, in the same write → FAIL with fail_chan = the mismatching channel. Final matching write in the same cycle the limit is reached → PASS, not TIMEOUT.
- No channels armed, start → PASS one cycle later. `cfg_we` during RUN has no effect. `clear` → IDLE with config intact; restart reproduces the result.
- Pull `reset` low mid-RUN between edges → state=0 and all channels disarmed before the next edge. Counters read 0.

Source files
------------

// File: rtl/opcheck_monitor.sv
// rtl/opcheck_monitor.sv - bus-watching checkpoint monitor deciding pass/fail/timeout for directed CPU tests
//
// Purpose:
//   Sits beside the memory on the CPU address/data bus. Each checkpoint channel
//   expects a masked data value to be written to a given address. The run ends in
//   PASS once every armed channel has been hit, FAIL on the first mismatching
//   write to an armed address, or TIMEOUT when the cycle budget runs out.
//
// Ports:
//   ph1            clock, all state changes on the rising edge
//   reset          asynchronous active-low reset
//   bus_valid      bus cycle in progress
//   bus_we         bus cycle is a write
//   bus_addr       bus address
//   bus_wdata      bus write data
//   cfg_we         write config of channel cfg_sel (IDLE only)
//   cfg_sel        channel index
//   cfg_arm        arm / disarm selected channel
//   cfg_addr       checkpoint address
//   cfg_data       expected value
//   cfg_mask       compare mask, 1 = bit compared
//   timeout_limit  cycle budget, latched on start (0 = no timeout)
//   start          IDLE -> RUN
//   clear          terminal state -> IDLE, config retained
//   state          IDLE=0 RUN=1 PASS=2 FAIL=3 TIMEOUT=4
//   done           state is PASS, FAIL or TIMEOUT
//   pass           state is PASS
//   hit_mask       channels satisfied this run
//   fail_chan      lowest-index channel that mismatched
//   fail_data      offending write data
//   cycle_count    clocks spent in RUN (saturating)
//   write_count    valid writes seen in RUN (saturating)

module opcheck_monitor #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                ph1,
  input  logic                reset,
  input  logic                bus_valid,
  input  logic                bus_we,
  input  logic [ADDR_W-1:0]   bus_addr,
  input  logic [DATA_W-1:0]   bus_wdata,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic                cfg_arm,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [DATA_W-1:0]   cfg_data,
  input  logic [DATA_W-1:0]   cfg_mask,
  input  logic [CNT_W-1:0]    timeout_limit,
  input  logic                start,
  input  logic                clear,
  output logic [2:0]          state,
  output logic                done,
  output logic                pass,
  output logic [CHANNELS-1:0] hit_mask,
  output logic [SEL_W-1:0]    fail_chan,
  output logic [DATA_W-1:0]   fail_data,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    write_count
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  state_e                           state_q, state_d;
  logic                             done_q, done_d;
  logic                             pass_q, pass_d;
  logic [CHANNELS-1:0]              arm_q, arm_d;
  logic [CHANNELS-1:0][ADDR_W-1:0]  addr_q, addr_d;
  logic [CHANNELS-1:0][DATA_W-1:0]  data_q, data_d;
  logic [CHANNELS-1:0][DATA_W-1:0]  mask_q, mask_d;
  logic [CHANNELS-1:0]              hit_q, hit_d;
  logic [SEL_W-1:0]                 fail_chan_q, fail_chan_d;
  logic [DATA_W-1:0]                fail_data_q, fail_data_d;
  logic [CNT_W-1:0]                 cycle_q, cycle_d;
  logic [CNT_W-1:0]                 wcount_q, wcount_d;
  logic [CNT_W-1:0]                 limit_q, limit_d;

  // Per-channel compare of the current bus write
  logic                             bus_wr;
  logic [CHANNELS-1:0]              match_vec;
  logic [CHANNELS-1:0]              mism_vec;
  logic [SEL_W-1:0]                 mism_idx;
  logic [CHANNELS-1:0]              hits_next;
  logic [CNT_W-1:0]                 cycle_inc;
  logic [CNT_W-1:0]                 wcount_inc;

  always_comb begin
    bus_wr    = bus_valid & bus_we;
    match_vec = '0;
    mism_vec  = '0;
    mism_idx  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus_wr && arm_q[i] && (bus_addr == addr_q[i])) begin
        if (((bus_wdata ^ data_q[i]) & mask_q[i]) == '0) begin
          match_vec[i] = 1'b1;
        end else begin
          mism_vec[i] = 1'b1;
        end
      end
    end
    // Walk downwards so the lowest mismatching index wins
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mism_vec[i]) begin
        mism_idx = SEL_W'(i);
      end
    end
    hits_next  = hit_q | match_vec;
    cycle_inc  = (cycle_q == '1) ? cycle_q : cycle_q + CNT_W'(1);
    wcount_inc = (wcount_q == '1) ? wcount_q : wcount_q + CNT_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    arm_d       = arm_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mask_d      = mask_q;
    hit_d       = hit_q;
    fail_chan_d = fail_chan_q;
    fail_data_d = fail_data_q;
    cycle_d     = cycle_q;
    wcount_d    = wcount_q;
    limit_d     = limit_q;

    case (state_q)
      ST_IDLE: begin
        if (cfg_we && (int'(cfg_sel) < CHANNELS)) begin
          arm_d[cfg_sel]  = cfg_arm;
          addr_d[cfg_sel] = cfg_addr;
          data_d[cfg_sel] = cfg_data;
          mask_d[cfg_sel] = cfg_mask;
        end
        // Config written alongside start lands in the registers before the
        // first evaluated bus cycle, so the run sees it.
        if (start) begin
          hit_d       = '0;
          fail_chan_d = '0;
          fail_data_d = '0;
          cycle_d     = '0;
          wcount_d    = '0;
          limit_d     = timeout_limit;
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        cycle_d = cycle_inc;
        hit_d   = hits_next;
        if (bus_wr) begin
          wcount_d = wcount_inc;
        end
        // Decision priority: FAIL, then PASS, then TIMEOUT
        if (|mism_vec) begin
          state_d     = ST_FAIL;
          fail_chan_d = mism_idx;
          fail_data_d = bus_wdata;
        end else if ((hits_next & arm_q) == arm_q) begin
          state_d = ST_PASS;
        end else if ((limit_q != '0) && (cycle_inc == limit_q)) begin
          state_d = ST_TIMEOUT;
        end
      end

      ST_PASS, ST_FAIL, ST_TIMEOUT: begin
        if (clear) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    done_d = (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
    pass_d = (state_d == ST_PASS);
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      arm_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      hit_q       <= '0;
      fail_chan_q <= '0;
      fail_data_q <= '0;
      cycle_q     <= '0;
      wcount_q    <= '0;
      limit_q     <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      arm_q       <= arm_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      hit_q       <= hit_d;
      fail_chan_q <= fail_chan_d;
      fail_data_q <= fail_data_d;
      cycle_q     <= cycle_d;
      wcount_q    <= wcount_d;
      limit_q     <= limit_d;
    end
  end

  assign state       = state_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign hit_mask    = hit_q;
  assign fail_chan   = fail_chan_q;
  assign fail_data   = fail_data_q;
  assign cycle_count = cycle_q;
  assign write_count = wcount_q;

endmodule

// File: tb/tb_opcheck_monitor.sv
// tb/tb_opcheck_monitor.sv - directed self-checking bench for opcheck_monitor

module tb_opcheck_monitor;

  logic        ph1;
  logic        reset;
  logic        bus_valid;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic        cfg_arm;
  logic [15:0] cfg_addr;
  logic [7:0]  cfg_data;
  logic [7:0]  cfg_mask;
  logic [15:0] timeout_limit;
  logic        start;
  logic        clear;
  logic [2:0]  state;
  logic        done;
  logic        pass;
  logic [3:0]  hit_mask;
  logic [1:0]  fail_chan;
  logic [7:0]  fail_data;
  logic [15:0] cycle_count;
  logic [15:0] write_count;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  opcheck_monitor #(
    .ADDR_W(16), .DATA_W(8), .CHANNELS(4), .CNT_W(16)
  ) dut (
    .ph1(ph1), .reset(reset),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_arm(cfg_arm), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_mask(cfg_mask), .timeout_limit(timeout_limit),
    .start(start), .clear(clear),
    .state(state), .done(done), .pass(pass), .hit_mask(hit_mask),
    .fail_chan(fail_chan), .fail_data(fail_data),
    .cycle_count(cycle_count), .write_count(write_count)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ph1);
    #1;
  endtask

  task automatic cfg(input logic [1:0] sel, input logic arm, input logic [15:0] a,
                     input logic [7:0] d, input logic [7:0] m);
    cfg_we = 1'b1; cfg_sel = sel; cfg_arm = arm; cfg_addr = a; cfg_data = d; cfg_mask = m;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    step();
    bus_valid = 1'b0; bus_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0; bus_valid = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_arm = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_mask = '0;
    timeout_limit = '0; start = 1'b0; clear = 1'b0;

    step();
    chk("rst_state", state, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_hit", hit_mask, 0);
    chk("rst_cycles", cycle_count, 0);
    chk("rst_writes", write_count, 0);
    reset = 1'b1;
    step();

    // Single channel exact match
    cfg(2'd0, 1'b1, 16'h0003, 8'h22, 8'hFF);
    do_start();
    chk("t1_run", state, 1);
    bus_wr(16'h0003, 8'h22);
    chk("t1_state", state, 2);
    chk("t1_pass", pass, 1);
    chk("t1_done", done, 1);
    chk("t1_hit", hit_mask, 4'b0001);
    chk("t1_writes", write_count, 1);
    chk("t1_cycles", cycle_count, 1);
    do_clear();
    chk("t1_clear", state, 0);

    // Masked compare: ch0 hits, ch2 mismatches
    cfg(2'd0, 1'b1, 16'h0010, 8'h5A, 8'hF0);
    cfg(2'd2, 1'b1, 16'h0020, 8'h5A, 8'hF0);
    do_start();
    bus_wr(16'h0010, 8'h5F);
    chk("t2_mid_state", state, 1);
    chk("t2_mid_hit", hit_mask, 4'b0001);
    bus_wr(16'h0020, 8'h6A);
    chk("t2_state", state, 3);
    chk("t2_fail_chan", fail_chan, 2);
    chk("t2_fail_data", fail_data, 8'h6A);
    chk("t2_hit", hit_mask, 4'b0001);
    chk("t2_writes", write_count, 2);
    chk("t2_pass", pass, 0);
    // Terminal: bus and start ignored, counters frozen
    start = 1'b1;
    bus_wr(16'h0010, 8'h5A);
    start = 1'b0;
    chk("t2_hold_state", state, 3);
    chk("t2_hold_writes", write_count, 2);
    chk("t2_hold_cycles", cycle_count, 2);
    do_clear();

    // Timeout after 5 RUN cycles; cfg_we during RUN ignored
    cfg(2'd0, 1'b0, 16'h0000, 8'h00, 8'h00);
    cfg(2'd2, 1'b0, 16'h0000, 8'h00, 8'h00);
    cfg(2'd1, 1'b1, 16'h0040, 8'h00, 8'hFF);
    timeout_limit = 16'd5;
    do_start();
    step();
    cfg(2'd1, 1'b1, 16'h0041, 8'h00, 8'hFF);
    bus_wr(16'h0041, 8'h00);
    step();
    chk("t3_run_state", state, 1);
    chk("t3_run_cycles", cycle_count, 4);
    chk("t3_run_writes", write_count, 1);
    step();
    chk("t3_state", state, 4);
    chk("t3_cycles", cycle_count, 5);
    chk("t3_done", done, 1);
    chk("t3_pass", pass, 0);
    do_clear();
    // Restart with retained config (ch1 still at 0x0040)
    do_start();
    bus_wr(16'h0040, 8'h00);
    chk("t3_restart_state", state, 2);
    chk("t3_restart_hit", hit_mask, 4'b0010);
    do_clear();

    // Two channels same address, one matches, one mismatches
    cfg(2'd1, 1'b0, 16'h0000, 8'h00, 8'h00);
    cfg(2'd0, 1'b1, 16'h0050, 8'h11, 8'hFF);
    cfg(2'd3, 1'b1, 16'h0050, 8'h22, 8'hFF);
    timeout_limit = 16'd0;
    do_start();
    bus_wr(16'h0050, 8'h11);
    chk("t4_state", state, 3);
    chk("t4_fail_chan", fail_chan, 3);
    chk("t4_fail_data", fail_data, 8'h11);
    do_clear();

    // Final match on the same cycle the limit is reached -> PASS
    cfg(2'd3, 1'b0, 16'h0000, 8'h00, 8'h00);
    cfg(2'd0, 1'b1, 16'h0060, 8'h33, 8'h0F);
    timeout_limit = 16'd3;
    do_start();
    step();
    step();
    chk("t5_run_state", state, 1);
    bus_wr(16'h0060, 8'hF3);
    chk("t5_state", state, 2);
    chk("t5_cycles", cycle_count, 3);
    do_clear();

    // Zero channels armed -> PASS one cycle after start
    cfg(2'd0, 1'b0, 16'h0000, 8'h00, 8'h00);
    timeout_limit = 16'd0;
    do_start();
    chk("t6_run", state, 1);
    step();
    chk("t6_state", state, 2);
    chk("t6_hit", hit_mask, 4'b0000);
    chk("t6_cycles", cycle_count, 1);
    do_clear();

    // cfg_we with start: config applies first, run waits for ch2
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_arm = 1'b1; cfg_addr = 16'h0070;
    cfg_data = 8'h44; cfg_mask = 8'hFF; start = 1'b1;
    step();
    cfg_we = 1'b0; start = 1'b0;
    step();
    chk("t7_wait_state", state, 1);
    chk("t7_wait_cycles", cycle_count, 1);
    // Asynchronous reset mid-run, checked before the next edge
    #2 reset = 1'b0;
    #1;
    chk("t7_rst_state", state, 0);
    chk("t7_rst_cycles", cycle_count, 0);
    chk("t7_rst_writes", write_count, 0);
    chk("t7_rst_done", done, 0);
    #2 reset = 1'b1;
    step();
    do_start();
    step();
    chk("t7_disarmed_pass", state, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
